spine_out_arbiter: RTL and testbench

Per-output-port packet arbiter for the group spine router. Shares one output port's out-FIFO write path among 11 input ports (4 leaf and 7 group ports) using round-robin. Holds the grant for the length of a packet (head plus body flits), honours FIFO-full backpressure, and drops stuck grants by watchdog. One instance sits beside each `router_port`, between the input FIFOs and that port's outgoing FIFO, under control of the routing FSM.

---
 rtl/spine_pkg.sv | 20 ++
 rtl/spine_rr_pick.sv | 38 +++
 rtl/spine_out_arbiter.sv | 178 +++++++++++++++++
 tb/tb_spine_out_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spine_pkg.sv
// Shared definitions for the group spine router: port count,
// head-flit field positions and the output arbiter state encoding.
package spine_pkg;

    localparam int NUM_SPINE_PORTS = 11;
    localparam int SPINE_IDX_W     = $clog2(NUM_SPINE_PORTS);

    localparam int HEAD_DEST_MSB = 15;
    localparam int HEAD_DEST_LSB = 10;
    localparam int HEAD_LEN_MSB  = 9;
    localparam int HEAD_LEN_LSB  = 6;
    localparam int LEN_W         = HEAD_LEN_MSB - HEAD_LEN_LSB + 1;

    typedef enum logic [1:0] {
        IDLE,
        HEAD,
        BODY
    } arb_state_t;

endpackage

// File: rtl/spine_rr_pick.sv
// Round-robin picker: first set request at or after rr_ptr,
// wrapping modulo N. Purely combinational.
module spine_rr_pick
    import spine_pkg::*;
#(
    parameter int N  = NUM_SPINE_PORTS,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] rr_ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] idx,
    output logic          hit
);

    localparam int JW = IW + 1;

    logic [JW-1:0] j;

    always_comb begin
        pick = '0;
        idx  = '0;
        hit  = 1'b0;
        j    = '0;
        for (int i = 0; i < N; i++) begin
            j = {1'b0, rr_ptr} + JW'(i);
            if (j >= JW'(N)) begin
                j = j - JW'(N);
            end
            if (!hit && req[j[IW-1:0]]) begin
                hit            = 1'b1;
                idx            = j[IW-1:0];
                pick[j[IW-1:0]] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/spine_out_arbiter.sv
// Per-output-port packet arbiter: round-robin grant held for a whole
// packet, out-FIFO backpressure, and a watchdog for stalled owners.
module spine_out_arbiter
    import spine_pkg::*;
#(
    parameter int NUM_PORTS   = NUM_SPINE_PORTS,
    parameter int DWIDTH      = 16,
    parameter int WDOG_CYCLES = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_PORTS-1:0]        req,
    input  logic [NUM_PORTS*DWIDTH-1:0] in_data,
    input  logic [NUM_PORTS-1:0]        in_valid,
    output logic [NUM_PORTS-1:0]        pop,
    input  logic                        out_full,
    output logic [DWIDTH-1:0]           out_data,
    output logic                        out_valid,
    output logic [NUM_PORTS-1:0]        grant,
    output logic                        busy,
    output logic                        wdog_err
);

    localparam int IW = $clog2(NUM_PORTS);
    localparam int WW = $clog2(WDOG_CYCLES + 1);

    arb_state_t           state_q, state_d;
    logic [NUM_PORTS-1:0] grant_q, grant_d;
    logic [IW-1:0]        gidx_q, gidx_d;
    logic [IW-1:0]        rr_ptr_q, rr_ptr_d;
    logic [LEN_W-1:0]     cnt_q, cnt_d;
    logic [WW-1:0]        wdog_q, wdog_d;
    logic                 cool_q, cool_d;
    logic [DWIDTH-1:0]    out_data_q, out_data_d;
    logic                 out_valid_q, out_valid_d;
    logic                 wdog_err_q, wdog_err_d;

    logic [NUM_PORTS-1:0] pick;
    logic [IW-1:0]        pick_idx;
    logic                 pick_hit;
    logic [DWIDTH-1:0]    sel_flit;
    logic                 sel_valid;
    logic                 xfer;
    logic                 release_pkt;
    logic [LEN_W-1:0]     head_len;
    logic [IW-1:0]        nxt_ptr;

    spine_rr_pick #(
        .N  (NUM_PORTS),
        .IW (IW)
    ) u_pick (
        .req    (req),
        .rr_ptr (rr_ptr_q),
        .pick   (pick),
        .idx    (pick_idx),
        .hit    (pick_hit)
    );

    always_comb begin
        sel_flit = '0;
        for (int i = 0; i < NUM_PORTS; i++) begin
            if (gidx_q == IW'(i)) begin
                sel_flit = in_data[i*DWIDTH +: DWIDTH];
            end
        end
    end

    assign sel_valid = in_valid[gidx_q];
    assign xfer      = (state_q != IDLE) && sel_valid && !out_full;
    assign pop       = xfer ? grant_q : '0;
    assign head_len  = sel_flit[HEAD_LEN_MSB:HEAD_LEN_LSB];
    assign nxt_ptr   = (gidx_q == IW'(NUM_PORTS - 1)) ? '0 : gidx_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        gidx_d      = gidx_q;
        rr_ptr_d    = rr_ptr_q;
        cnt_d       = cnt_q;
        wdog_d      = wdog_q;
        cool_d      = cool_q;
        out_data_d  = out_data_q;
        out_valid_d = xfer;
        wdog_err_d  = 1'b0;
        release_pkt = 1'b0;

        if (xfer) begin
            out_data_d = sel_flit;
        end

        unique case (state_q)
            IDLE: begin
                // First IDLE cycle after a packet never re-grants.
                if (cool_q) begin
                    cool_d = 1'b0;
                end else if (pick_hit) begin
                    grant_d = pick;
                    gidx_d  = pick_idx;
                    state_d = HEAD;
                end
            end
            HEAD: begin
                if (xfer) begin
                    cnt_d = head_len;
                    if (head_len == '0) begin
                        release_pkt = 1'b1;
                    end else begin
                        state_d = BODY;
                    end
                end
            end
            BODY: begin
                if (xfer) begin
                    cnt_d = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
                    if (cnt_q <= LEN_W'(1)) begin
                        release_pkt = 1'b1;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (state_q != IDLE) begin
            if (xfer) begin
                wdog_d = '0;
            end else if (wdog_q == WW'(WDOG_CYCLES - 1)) begin
                release_pkt = 1'b1;
                wdog_err_d  = 1'b1;
            end else begin
                wdog_d = wdog_q + 1'b1;
            end
        end

        if (release_pkt) begin
            state_d  = IDLE;
            grant_d  = '0;
            rr_ptr_d = nxt_ptr;
            cnt_d    = '0;
            wdog_d   = '0;
            cool_d   = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            gidx_q      <= '0;
            rr_ptr_q    <= '0;
            cnt_q       <= '0;
            wdog_q      <= '0;
            cool_q      <= 1'b0;
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            wdog_err_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            gidx_q      <= gidx_d;
            rr_ptr_q    <= rr_ptr_d;
            cnt_q       <= cnt_d;
            wdog_q      <= wdog_d;
            cool_q      <= cool_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            wdog_err_q  <= wdog_err_d;
        end
    end

    assign grant     = grant_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign wdog_err  = wdog_err_q;
    assign busy      = (state_q != IDLE);

endmodule

// File: tb/tb_spine_out_arbiter.sv
// Directed bench for spine_out_arbiter: input FIFO models feed the
// arbiter, a scoreboard queue holds the flits expected at the output.
module tb_spine_out_arbiter;

    localparam int NP = 11;
    localparam int DW = 16;

    logic             clk;
    logic             reset;
    logic [NP-1:0]    req;
    logic [NP*DW-1:0] in_data;
    logic [NP-1:0]    in_valid;
    logic [NP-1:0]    pop;
    logic             out_full;
    logic [DW-1:0]    out_data;
    logic             out_valid;
    logic [NP-1:0]    grant;
    logic             busy;
    logic             wdog_err;

    spine_out_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .pop       (pop),
        .out_full  (out_full),
        .out_data  (out_data),
        .out_valid (out_valid),
        .grant     (grant),
        .busy      (busy),
        .wdog_err  (wdog_err)
    );

    logic [DW-1:0] fifo [NP][$];
    logic [DW-1:0] sb [$];
    int            ovt [$];
    logic [NP-1:0] reqen;
    logic [NP-1:0] hold;
    logic [NP-1:0] p_s;
    int            checks = 0;
    int            errs   = 0;
    int            nout   = 0;
    int            nwd    = 0;
    int            cyc_n  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic void refresh();
        for (int i = 0; i < NP; i++) begin
            logic ne;
            ne = fifo[i].size() != 0;
            in_valid[i]        = ne && !hold[i];
            in_data[i*DW +: DW] = ne ? fifo[i][0] : '0;
            req[i]             = ne && reqen[i];
        end
    endfunction

    // FIFO model: pop strobes sampled at the edge, queues updated after it
    always @(clk) begin
        if (clk) begin
            p_s = pop;
            if (!reset) begin
                chk("pop_onehot", {31'd0, $onehot0(p_s)}, 32'd1);
                chk("pop_valid", {21'd0, p_s & ~in_valid}, 32'd0);
            end
            #1;
            for (int i = 0; i < NP; i++) begin
                if (p_s[i] && fifo[i].size() != 0) begin
                    void'(fifo[i].pop_front());
                end
            end
        end else begin
            #1;
        end
        refresh();
    end

    always @(posedge clk) cyc_n <= cyc_n + 1;

    always @(negedge clk) begin
        logic [31:0] exp;
        if (out_valid === 1'b1) begin
            nout++;
            ovt.push_back(cyc_n);
            exp = (sb.size() != 0) ? {16'd0, sb.pop_front()} : 'x;
            chk("sb_flit", {16'd0, out_data}, exp);
        end
        if (wdog_err === 1'b1) nwd++;
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic push(input int port, input logic [DW-1:0] f);
        fifo[port].push_back(f);
    endtask

    task automatic wait_idle(input int budget);
        int k = 0;
        while (busy && k < budget) begin
            cyc(1);
            k++;
        end
        chk("idle", {31'd0, busy}, 32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc(2);
        reset = 1'b0;
    endtask

    initial begin
        int k;
        int n0;
        logic [DW-1:0] h;
        reset    = 1'b1;
        reqen    = '0;
        hold     = '0;
        out_full = 1'b0;
        cyc(2);
        chk("rst_grant", {21'd0, grant}, 32'd0);
        chk("rst_oval", {31'd0, out_valid}, 32'd0);
        chk("rst_odata", {16'd0, out_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_wdog", {31'd0, wdog_err}, 32'd0);
        chk("rst_ptr", {28'd0, dut.rr_ptr_q}, 32'd0);
        reset = 1'b0;
        cyc(1);

        // single packet from port 2
        push(2, 16'hFC40);
        push(2, 16'h1234);
        sb.push_back(16'hFC40);
        sb.push_back(16'h1234);
        reqen = 11'h004;
        cyc(1);
        chk("t1_grant", {21'd0, grant}, 32'h004);
        reqen = '0;
        cyc(1);
        chk("t1_v0", {31'd0, out_valid}, 32'd1);
        chk("t1_d0", {16'd0, out_data}, 32'hFC40);
        cyc(1);
        chk("t1_v1", {31'd0, out_valid}, 32'd1);
        chk("t1_d1", {16'd0, out_data}, 32'h1234);
        cyc(1);
        chk("t1_busy", {31'd0, busy}, 32'd0);
        chk("t1_ptr", {28'd0, dut.rr_ptr_q}, 32'd3);
        cyc(2);

        // fairness: every port requests, single-flit packets
        do_reset();
        for (int i = 0; i < NP; i++) begin
            h = {i[5:0], 4'd0, i[5:0]};
            push(i, h);
            sb.push_back(h);
        end
        push(0, 16'h003F);
        sb.push_back(16'h003F);
        ovt.delete();
        reqen = '1;
        k = 0;
        while (sb.size() != 0 && k < 80) begin
            cyc(1);
            k++;
        end
        reqen = '0;
        chk("fair_left", sb.size(), 32'd0);
        chk("fair_n", ovt.size(), 32'd12);
        for (int i = 1; i < ovt.size(); i++) begin
            chk("fair_gap", ovt[i] - ovt[i-1], 32'd3);
        end
        wait_idle(10);
        cyc(2);

        // backpressure mid-body on port 5
        push(5, 16'h24C5);
        sb.push_back(16'h24C5);
        for (int i = 1; i <= 3; i++) begin
            h = 16'hA000 | 16'(i);
            push(5, h);
            sb.push_back(h);
        end
        n0 = nout;
        reqen = 11'h020;
        cyc(1);
        chk("bp_grant", {21'd0, grant}, 32'h020);
        reqen = '0;
        cyc(1);
        out_full = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            chk("bp_pop", {21'd0, pop}, 32'd0);
            chk("bp_oval", {31'd0, out_valid}, 32'd0);
        end
        out_full = 1'b0;
        wait_idle(20);
        cyc(2);
        chk("bp_left", sb.size(), 32'd0);
        chk("bp_count", nout - n0, 32'd4);

        // watchdog: port 7 granted, its FIFO never presents a flit
        hold[7] = 1'b1;
        push(7, 16'h1C87);
        push(7, 16'hD001);
        push(7, 16'hD002);
        push(8, 16'h2008);
        n0 = nwd;
        reqen = 11'h080;
        cyc(1);
        chk("wd_grant", {21'd0, grant}, 32'h080);
        reqen = '0;
        k = 0;
        do begin
            cyc(1);
            k++;
        end while (!wdog_err && k < 40);
        chk("wd_cycles", k, 32'd32);
        chk("wd_busy", {31'd0, busy}, 32'd0);
        chk("wd_ptr", {28'd0, dut.rr_ptr_q}, 32'd8);
        cyc(1);
        chk("wd_pulse", {31'd0, wdog_err}, 32'd0);
        sb.push_back(16'h2008);
        reqen = 11'h100;
        cyc(1);
        chk("wd_next", {21'd0, grant}, 32'h100);
        reqen = '0;
        wait_idle(10);
        cyc(2);
        chk("wd_once", nwd - n0, 32'd1);
        chk("wd_left", sb.size(), 32'd0);
        fifo[7].delete();
        hold[7] = 1'b0;
        cyc(1);

        // reset in the middle of a 16-flit packet from port 0
        push(0, 16'h07C0);
        sb.push_back(16'h07C0);
        for (int i = 1; i <= 15; i++) begin
            h = 16'hB000 | 16'(i);
            push(0, h);
            if (i <= 4) sb.push_back(h);
        end
        reqen = 11'h001;
        cyc(1);
        chk("mr_grant", {21'd0, grant}, 32'h001);
        reqen = '0;
        cyc(5);
        reset = 1'b1;
        cyc(1);
        chk("mr_grant0", {21'd0, grant}, 32'd0);
        chk("mr_oval", {31'd0, out_valid}, 32'd0);
        chk("mr_busy", {31'd0, busy}, 32'd0);
        chk("mr_ptr", {28'd0, dut.rr_ptr_q}, 32'd0);
        reset = 1'b0;
        fifo[0].delete();
        chk("mr_left", sb.size(), 32'd0);
        cyc(2);

        // late request from port 3 during port 4's body
        push(4, 16'h0884);
        push(4, 16'hC001);
        push(4, 16'hC002);
        push(3, 16'h0C03);
        sb.push_back(16'h0884);
        sb.push_back(16'hC001);
        sb.push_back(16'hC002);
        sb.push_back(16'h0C03);
        reqen = 11'h010;
        cyc(1);
        chk("lr_grant4", {21'd0, grant}, 32'h010);
        cyc(1);
        reqen = 11'h008;
        cyc(1);
        chk("lr_hold4", {21'd0, grant}, 32'h010);
        cyc(1);
        chk("lr_gap0", {21'd0, grant}, 32'd0);
        cyc(1);
        chk("lr_gap1", {21'd0, grant}, 32'd0);
        cyc(1);
        chk("lr_grant3", {21'd0, grant}, 32'h008);
        reqen = '0;
        wait_idle(10);
        cyc(2);
        chk("lr_left", sb.size(), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errs);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

endmodule
